// File: rtl/lsu.sv
// Load/store unit: aligns stores onto a 32-bit word bus and extends load data.
// Define LSU_ALIGN_CHECK_EN to report misaligned half/word accesses as errors.
module lsu #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wen,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wmask,
  input  logic              bus_resp_valid,
  input  logic [31:0]       bus_resp_data
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              wen_q, wen_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_wen_q, bus_wen_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_wmask_q, bus_wmask_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        illegal, misaligned, is_half, is_word;
  logic [1:0]  req_off;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic [31:0] ld_shifted;
  logic [31:0] ld_data;

  // Request decode: legality, alignment and effective lane offset.
  always_comb begin
    is_half = (req_op[1:0] == 2'b01);
    is_word = (req_op[1:0] == 2'b10);
    illegal = (req_op == 3'b011) || (req_op[2:1] == 2'b11) || (req_wen && req_op[2]);
`ifdef LSU_ALIGN_CHECK_EN
    misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    req_off    = req_addr[1:0];
`else
    // Without the check, misaligned accesses are silently forced onto an aligned lane.
    misaligned = 1'b0;
    req_off    = is_word ? 2'b00 : (is_half ? {req_addr[1], 1'b0} : req_addr[1:0]);
`endif
  end

  always_comb begin
    st_data = req_wdata;
    st_mask = 4'b1111;
    unique case (req_op[1:0])
      2'b00: begin
        st_data = {4{req_wdata[7:0]}};
        st_mask = 4'b0001 << req_off;
      end
      2'b01: begin
        st_data = {2{req_wdata[15:0]}};
        st_mask = 4'b0011 << req_off;
      end
      default: begin
        st_data = req_wdata;
        st_mask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_shifted = bus_resp_data >> {off_q, 3'b000};
    unique case (op_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_data = {24'h0, ld_shifted[7:0]};
      3'b101:  ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = bus_resp_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    op_d        = op_q;
    off_d       = off_q;
    bus_addr_d  = bus_addr_q;
    bus_wen_d   = bus_wen_q;
    bus_wdata_d = bus_wdata_q;
    bus_wmask_d = bus_wmask_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          wen_d = req_wen;
          op_d  = req_op;
          off_d = req_off;
          if (illegal || misaligned) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = StResp;
          end else begin
            bus_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            bus_wen_d   = req_wen;
            bus_wdata_d = st_data;
            bus_wmask_d = req_wen ? st_mask : 4'b0000;
            err_d       = 1'b0;
            rdata_d     = 32'h0;
            state_d     = StReq;
          end
        end
      end
      StReq: begin
        if (bus_req_ready) state_d = StWait;
      end
      StWait: begin
        if (bus_resp_valid) begin
          rdata_d = wen_q ? 32'h0 : ld_data;
          err_d   = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wen_q       <= 1'b0;
      op_q        <= 3'b000;
      off_q       <= 2'b00;
      bus_addr_q  <= '0;
      bus_wen_q   <= 1'b0;
      bus_wdata_q <= 32'h0;
      bus_wmask_q <= 4'b0000;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      op_q        <= op_d;
      off_q       <= off_d;
      bus_addr_q  <= bus_addr_d;
      bus_wen_q   <= bus_wen_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign bus_req_valid = (state_q == StReq);
  assign resp_valid    = (state_q == StResp);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wen       = bus_wen_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wmask     = bus_wmask_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the data-memory bus. Executes the memory operation the decoder selects (`memOP` = func3, `memWriteEnable`) on one decoded instruction at a time: it aligns store data and byte mask onto a 32-bit word bus, then sign- or zero-extends load data. It runs a valid/ready handshake on both sides, and the core stalls on `req_ready`/`resp_valid`.

## Interface
- `ADDR_W`, 32, byte-address width.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: execute stage presents a memory op.
- `req_ready` output 1: LSU accepts the op.
- `req_wen` input 1: 1 = store, 0 = load (decoder `memWriteEnable`).
- `req_op` input 3: func3 (`memOP`).
- `req_addr` input ADDR_W: effective address (ALU result).
- `req_wdata` input 32: rs2 value.
- `resp_valid` output 1: result available.
- `resp_ready` input 1: consumer takes the result.
- `resp_rdata` output 32: extended load data; 0 for stores.
- `resp_err` output 1: misaligned or illegal op.
- `bus_req_valid` output 1: bus request.
- `bus_req_ready` input 1: bus accepts the request.
- `bus_addr` output ADDR_W: word-aligned address, low 2 bits = 0.
- `bus_wen` output 1: write.
- `bus_wdata` output 32: lane-shifted store data.
- `bus_wmask` output 4: byte-lane enables; 0 on reads.
- `bus_resp_valid` input 1: read data or write ack.
- `bus_resp_data` input 32: read word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. `req_ready` = (state == IDLE).
- IDLE: on `req_valid`, latch wen, op, addr and wdata, then decode:
  - op 011, 110 and 111 are illegal. Stores with op[2]=1 are also illegal.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Illegal or misaligned goes to RESP with err=1 and rdata=0, and issues no bus transaction. Otherwise the FSM goes to REQ.
- REQ: `bus_req_valid`=1. Address, wen, wdata and wmask are held stable until `bus_req_ready`, then the FSM goes to WAIT.
- WAIT: on `bus_resp_valid`, capture the extended data (loads) or 0 (stores), then go to RESP.
- RESP: `resp_valid`=1 with rdata and err stable. On `resp_ready` the FSM goes to IDLE.
- Store lanes, with off = addr[1:0]:
  - SB: wdata[7:0] replicated to every byte; mask = 0001 << off.
  - SH: wdata[15:0] replicated to both halves; mask = 0011 << off.
  - SW: mask = 1111.
- Load extraction: byte/half selected by off, then extended:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- `bus_resp_valid` is ignored outside WAIT. `req_valid` is ignored outside IDLE.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, bus_req_valid=0, bus_addr=0, bus_wen=0, bus_wdata=0, bus_wmask=0.
- All outputs come from registers or state decode. There is no combinational path from any input to any output.
- Zero-wait path: accept in cycle N, `bus_req_valid` in N+1. With `bus_req_ready` high in N+1 and `bus_resp_valid` in N+2, `resp_valid` rises in N+3.
- Error path: accept in N, `resp_valid` with err in N+1.
- Back-to-back ops: the next accept is possible in the cycle after the `resp_valid`&`resp_ready` handshake.
- Reset mid-operation, in any state, returns to IDLE the next cycle. A bus response still in flight after reset is dropped by the IDLE-ignore rule.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined: misalignment detection as above, reported on `resp_err` with no bus access.
- Not defined: no alignment check and `resp_err` flags illegal ops only. Misaligned halfword/word accesses use off forced to an aligned value (addr[0] cleared for halves, addr[1:0] cleared for words) and proceed normally on the bus.

## Test plan
- LB at 0x80000003, bus word 0x80FF1234 → bus_addr 0x80000000, wmask 0000, resp_rdata 0xFFFFFF80, err 0.
- LHU at 0x80000002, bus word 0x80FF1234 → resp_rdata 0x000080FF; LH at the same address → 0xFFFF80FF.
- SB at 0x80000001, wdata 0x123456AB → bus_wen 1, wmask 0010, bus_wdata[15:8]=0xAB, resp_rdata 0.
- LW at 0x80000002 with the macro defined → resp_valid at N+1, err 1, bus_req_valid never asserted. Without the macro → bus_addr 0x80000000, err 0.
- Backpressure: hold `bus_req_ready` low 3 cycles and `resp_ready` low 2 cycles. Bus and response signals stay stable throughout, and exactly one transaction completes.
- Assert `rst` during WAIT, then deliver `bus_resp_valid` → all outputs at reset values, no `resp_valid`, next request served correctly.
